// File: rtl/trdb_pkg.sv
// Shared trace-decoder definitions.
// Contents:
//   - packet format and F_SYNC subformat encodings
//   - bit positions inside the encapsulation header byte
//   - a header sanity check used by the decoder FSM
package trdb_pkg;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_subformat_e;

    // Header byte: length[4:0], flow[6:5], extend[7]
    localparam int HDR_LEN_MSB  = 4;
    localparam int HDR_FLOW_LSB = 5;
    localparam int HDR_EXT_BIT  = 7;

    // A header is unusable when it asks for an extended header or for more
    // payload than the reassembly register can hold.
    function automatic logic hdr_malformed(input logic [7:0] hdr, input logic [5:0] max_len);
        return hdr[HDR_EXT_BIT] | ({1'b0, hdr[HDR_LEN_MSB:0]} > max_len);
    endfunction

endpackage

// File: rtl/trdb_pkt_decoder_if.sv
// Handshake bundle of the packet decoder.
// Signals:
//   - stream side: valid_i / ready_o / data_i
//   - packet side: valid_o / ready_i plus the decoded fields and error_o
// Modports:
//   - slave : decoder view
//   - master: producer/consumer (testbench or host) view
interface trdb_pkt_decoder_if #(
    parameter int PAYLOAD_W = 128
);
    logic                 valid_i;
    logic                 ready_o;
    logic [7:0]           data_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [1:0]           packet_format_o;
    logic [1:0]           packet_f_sync_subformat_o;
    logic [1:0]           flow_o;
    logic [4:0]           payload_len_o;
    logic [PAYLOAD_W-1:0] payload_o;
    logic                 error_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, packet_format_o, packet_f_sync_subformat_o,
               flow_o, payload_len_o, payload_o, error_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, packet_format_o, packet_f_sync_subformat_o,
               flow_o, payload_len_o, payload_o, error_o
    );
endinterface

// File: rtl/trdb_pkt_assembler.sv
// Payload reassembly register: byte k of the packet lands at bits [8k+7:8k].
// Ports:
//   - clk_i, rst_ni: clock, asynchronous active-low reset
//   - clr_i        : zero the whole register (start of a new packet)
//   - we_i, idx_i  : write data_i into byte slot idx_i
//   - payload_o    : registered payload
module trdb_pkt_assembler #(
    parameter int MAX_BYTES = 16,
    parameter int PAYLOAD_W = 8 * MAX_BYTES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [4:0]           idx_i,
    input  logic [7:0]           data_i,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic [PAYLOAD_W-1:0] payload_r;

    // Clear wins over write; slots not addressed keep their value, so bytes
    // beyond the packet length stay zero after the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            payload_r <= '0;
        end else if (clr_i) begin
            payload_r <= '0;
        end else if (we_i) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
                if (idx_i == 5'(k)) begin
                    payload_r[8*k +: 8] <= data_i;
                end
            end
        end
    end

    assign payload_o = payload_r;

endmodule

// File: rtl/trdb_pkt_decoder.sv
// Receive-side trace packet decoder.
// Strips the one-byte encapsulation header, reassembles the LSB-first
// payload and presents one decoded packet at a time.
// Ports:
//   - clk_i, rst_ni: clock, asynchronous active-low reset
//   - bus          : trdb_pkt_decoder_if.slave (byte stream in, packet out)
module trdb_pkt_decoder
    import trdb_pkg::*;
#(
    parameter int MAX_BYTES = 16,
    parameter int PAYLOAD_W = 8 * MAX_BYTES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    trdb_pkt_decoder_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DROP    = 2'd2,
        S_HOLD    = 2'd3
    } state_e;

    localparam logic [5:0] MAX_LEN = 6'(MAX_BYTES);

    state_e               state_r, state_nxt;
    logic [4:0]           idx_r, idx_nxt;
    logic [4:0]           rem_r, rem_nxt;
    logic [4:0]           len_r, len_nxt;
    logic [1:0]           flow_r, flow_nxt;
    logic                 err_r, err_nxt;
    logic                 clr_s, we_s, ready_s, accept_s;
    logic [4:0]           hdr_len_s;
    logic [1:0]           hdr_flow_s;
    logic [PAYLOAD_W-1:0] payload_s;
    trdb_format_e         fmt_s;
    logic [1:0]           sub_s;

    // ready_o depends on state only, never on ready_i
    assign ready_s    = (state_r != S_HOLD);
    assign accept_s   = bus.valid_i & ready_s;
    assign hdr_len_s  = bus.data_i[HDR_LEN_MSB:0];
    assign hdr_flow_s = bus.data_i[HDR_FLOW_LSB +: 2];

    // State and bookkeeping registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
            idx_r   <= 5'd0;
            rem_r   <= 5'd0;
            len_r   <= 5'd0;
            flow_r  <= 2'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            idx_r   <= idx_nxt;
            rem_r   <= rem_nxt;
            len_r   <= len_nxt;
            flow_r  <= flow_nxt;
            err_r   <= err_nxt;
        end
    end

    // Next-state logic and assembler controls
    always_comb begin
        state_nxt = state_r;
        idx_nxt   = idx_r;
        rem_nxt   = rem_r;
        len_nxt   = len_r;
        flow_nxt  = flow_r;
        err_nxt   = 1'b0;
        clr_s     = 1'b0;
        we_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!accept_s) begin
                    state_nxt = S_IDLE;
                end else if (hdr_len_s == 5'd0) begin
                    // idle filler byte: nothing to decode
                    state_nxt = S_IDLE;
                end else if (hdr_malformed(bus.data_i, MAX_LEN)) begin
                    state_nxt = S_DROP;
                    rem_nxt   = hdr_len_s;
                end else begin
                    clr_s     = 1'b1;
                    len_nxt   = hdr_len_s;
                    flow_nxt  = hdr_flow_s;
                    idx_nxt   = 5'd0;
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept_s) begin
                    we_s = 1'b1;
                    if (idx_r == (len_r - 5'd1)) begin
                        state_nxt = S_HOLD;
                    end else begin
                        idx_nxt = idx_r + 5'd1;
                    end
                end else begin
                    state_nxt = S_COLLECT;
                end
            end
            S_DROP: begin
                if (accept_s) begin
                    if (rem_r == 5'd1) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        rem_nxt = rem_r - 5'd1;
                    end
                end else begin
                    state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (bus.ready_i) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    trdb_pkt_assembler #(
        .MAX_BYTES (MAX_BYTES),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_asm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_s),
        .we_i      (we_s),
        .idx_i     (idx_r),
        .data_i    (bus.data_i),
        .payload_o (payload_s)
    );

    // Format/subformat decode from the registered payload; the subformat
    // only has meaning for F_SYNC packets.
    always_comb begin
        fmt_s = trdb_format_e'(payload_s[1:0]);
        sub_s = 2'd0;
        case (fmt_s)
            F_SYNC:  sub_s = payload_s[3:2];
            default: sub_s = 2'd0;
        endcase
    end

    assign bus.ready_o                   = ready_s;
    assign bus.valid_o                   = (state_r == S_HOLD);
    assign bus.error_o                   = err_r;
    assign bus.packet_format_o           = fmt_s;
    assign bus.packet_f_sync_subformat_o = sub_s;
    assign bus.flow_o                    = flow_r;
    assign bus.payload_len_o             = len_r;
    assign bus.payload_o                 = payload_s;

endmodule
